// File: rtl/fc_credit_tracker.sv
// Transmit-side flow-control credit tracker: runs the InitFC1/InitFC2 handshake, then keeps
// per-type credit limits (from received FC DLLPs) and credits-consumed counters (from sent TLPs).
module fc_credit_tracker #(
    parameter int INFO_SIGNALS = 10,
    parameter int HDR_INIT_INF = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    link_up,
    input  logic                    dllp_valid,
    input  logic [1:0]              dllp_kind,
    input  logic [1:0]              dllp_class,
    input  logic [INFO_SIGNALS-1:0] dllp_hdr_fc,
    input  logic [INFO_SIGNALS-1:0] dllp_data_fc,
    input  logic                    tlp_sent,
    input  logic [1:0]              tlp_class,
    input  logic [INFO_SIGNALS-1:0] tlp_data_credits,
    output logic [INFO_SIGNALS-1:0] PH_credit_limit,
    output logic [INFO_SIGNALS-1:0] PD_credit_limit,
    output logic [INFO_SIGNALS-1:0] NPH_credit_limit,
    output logic [INFO_SIGNALS-1:0] NPD_credit_limit,
    output logic [INFO_SIGNALS-1:0] CH_credit_limit,
    output logic [INFO_SIGNALS-1:0] CD_credit_limit,
    output logic [INFO_SIGNALS-1:0] PH_credit_consumed,
    output logic [INFO_SIGNALS-1:0] PD_credit_consumed,
    output logic [INFO_SIGNALS-1:0] NPH_credit_consumed,
    output logic [INFO_SIGNALS-1:0] NPD_credit_consumed,
    output logic [INFO_SIGNALS-1:0] CH_credit_consumed,
    output logic [INFO_SIGNALS-1:0] CD_credit_consumed,
    output logic [5:0]              infinite_flags,
    output logic                    fc_init_done,
    output logic                    protocol_err
);

    localparam logic [1:0] KIND_INIT1  = 2'b00;
    localparam logic [1:0] KIND_UPDATE = 2'b10;
    localparam logic [1:0] RSVD        = 2'b11;
    localparam logic [INFO_SIGNALS-1:0] INF_VAL = INFO_SIGNALS'(HDR_INIT_INF);
    localparam logic [INFO_SIGNALS-1:0] ONE     = INFO_SIGNALS'(1);

    typedef enum logic [1:0] {
        FC_INIT1,
        FC_INIT2,
        FC_ACTIVE
    } fc_state_e;

    fc_state_e              state_q, state_d;
    logic [2:0]             got_q, got_d;
    logic [5:0]             inf_q, inf_d;
    logic                   err_q, err_d;
    logic [INFO_SIGNALS-1:0] lim_q  [6];
    logic [INFO_SIGNALS-1:0] lim_d  [6];
    logic [INFO_SIGNALS-1:0] cons_q [6];
    logic [INFO_SIGNALS-1:0] cons_d [6];

    logic       dllp_ok;
    logic       tlp_ok;
    logic [2:0] dh, dd, th, td;

    // Type index = class*2 + (0 header, 1 data), matching the infinite_flags bit order.
    assign dh      = {dllp_class, 1'b0};
    assign dd      = {dllp_class, 1'b1};
    assign th      = {tlp_class, 1'b0};
    assign td      = {tlp_class, 1'b1};
    assign dllp_ok = dllp_valid && (dllp_kind != RSVD) && (dllp_class != RSVD);
    assign tlp_ok  = tlp_sent && (tlp_class != RSVD);

    always_comb begin
        state_d = state_q;
        got_d   = got_q;
        inf_d   = inf_q;
        err_d   = 1'b0;
        lim_d   = lim_q;
        cons_d  = cons_q;

        if (!link_up) begin
            state_d = FC_INIT1;
            got_d   = '0;
            inf_d   = '0;
            lim_d   = '{default: '0};
            cons_d  = '{default: '0};
        end else begin
            if (dllp_valid && ((dllp_kind == RSVD) || (dllp_class == RSVD)))
                err_d = 1'b1;
            if (tlp_sent && ((state_q != FC_ACTIVE) || (tlp_class == RSVD)))
                err_d = 1'b1;

            unique case (state_q)
                FC_INIT1: begin
                    if (got_q == 3'b111) begin
                        state_d = FC_INIT2;
                    end else if (dllp_ok && (dllp_kind == KIND_INIT1) && !got_q[dllp_class]) begin
                        lim_d[dh]         = dllp_hdr_fc;
                        lim_d[dd]         = dllp_data_fc;
                        inf_d[dh]         = (dllp_hdr_fc == INF_VAL);
                        inf_d[dd]         = (dllp_data_fc == INF_VAL);
                        got_d[dllp_class] = 1'b1;
                    end
                end
                FC_INIT2: begin
                    if (dllp_ok && (dllp_kind != KIND_INIT1))
                        state_d = FC_ACTIVE;
                end
                FC_ACTIVE: begin
                    if (dllp_ok && (dllp_kind == KIND_UPDATE)) begin
                        if (!inf_q[dh]) lim_d[dh] = dllp_hdr_fc;
                        if (!inf_q[dd]) lim_d[dd] = dllp_data_fc;
                    end
                    if (tlp_ok) begin
                        cons_d[th] = cons_q[th] + ONE;
                        cons_d[td] = cons_q[td] + tlp_data_credits;
                    end
                end
                default: state_d = FC_INIT1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FC_INIT1;
            got_q   <= '0;
            inf_q   <= '0;
            err_q   <= 1'b0;
            lim_q   <= '{default: '0};
            cons_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            inf_q   <= inf_d;
            err_q   <= err_d;
            lim_q   <= lim_d;
            cons_q  <= cons_d;
        end
    end

    assign PH_credit_limit     = lim_q[0];
    assign PD_credit_limit     = lim_q[1];
    assign NPH_credit_limit    = lim_q[2];
    assign NPD_credit_limit    = lim_q[3];
    assign CH_credit_limit     = lim_q[4];
    assign CD_credit_limit     = lim_q[5];
    assign PH_credit_consumed  = cons_q[0];
    assign PD_credit_consumed  = cons_q[1];
    assign NPH_credit_consumed = cons_q[2];
    assign NPD_credit_consumed = cons_q[3];
    assign CH_credit_consumed  = cons_q[4];
    assign CD_credit_consumed  = cons_q[5];
    assign infinite_flags      = inf_q;
    assign fc_init_done        = (state_q == FC_ACTIVE);
    assign protocol_err        = err_q;

endmodule

// File: tb/tb_fc_credit_tracker.sv
// Bench for fc_credit_tracker: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a behavioural credit model.
module tb_fc_credit_tracker;

    localparam int W = 10;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n, link_up, dllp_valid, tlp_sent;
    logic [1:0]   dllp_kind, dllp_class, tlp_class;
    logic [W-1:0] dllp_hdr_fc, dllp_data_fc, tlp_data_credits;
    logic [W-1:0] PH_credit_limit, PD_credit_limit, NPH_credit_limit, NPD_credit_limit;
    logic [W-1:0] CH_credit_limit, CD_credit_limit;
    logic [W-1:0] PH_credit_consumed, PD_credit_consumed, NPH_credit_consumed;
    logic [W-1:0] NPD_credit_consumed, CH_credit_consumed, CD_credit_consumed;
    logic [5:0]   infinite_flags;
    logic         fc_init_done, protocol_err;

    fc_credit_tracker #(.INFO_SIGNALS(W), .HDR_INIT_INF(0)) dut (
        .clk(clk), .rst_n(rst_n), .link_up(link_up),
        .dllp_valid(dllp_valid), .dllp_kind(dllp_kind), .dllp_class(dllp_class),
        .dllp_hdr_fc(dllp_hdr_fc), .dllp_data_fc(dllp_data_fc),
        .tlp_sent(tlp_sent), .tlp_class(tlp_class), .tlp_data_credits(tlp_data_credits),
        .PH_credit_limit(PH_credit_limit), .PD_credit_limit(PD_credit_limit),
        .NPH_credit_limit(NPH_credit_limit), .NPD_credit_limit(NPD_credit_limit),
        .CH_credit_limit(CH_credit_limit), .CD_credit_limit(CD_credit_limit),
        .PH_credit_consumed(PH_credit_consumed), .PD_credit_consumed(PD_credit_consumed),
        .NPH_credit_consumed(NPH_credit_consumed), .NPD_credit_consumed(NPD_credit_consumed),
        .CH_credit_consumed(CH_credit_consumed), .CD_credit_consumed(CD_credit_consumed),
        .infinite_flags(infinite_flags), .fc_init_done(fc_init_done),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    string onames [12] = '{"PH_lim", "PD_lim", "NPH_lim", "NPD_lim", "CH_lim", "CD_lim",
                           "PH_cons", "PD_cons", "NPH_cons", "NPD_cons", "CH_cons", "CD_cons"};

    // Reference model: handshake phase 0/1/2 = waiting InitFC1s / waiting InitFC2 / active.
    int m_phase;
    bit m_got [3];
    int m_lim [6];
    int m_cons[6];
    bit m_inf [6];
    bit m_err;

    function automatic void model_clear();
        m_phase = 0;
        m_err   = 0;
        for (int i = 0; i < 3; i++) m_got[i] = 0;
        for (int i = 0; i < 6; i++) begin
            m_lim[i] = 0; m_cons[i] = 0; m_inf[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int  c, k, tc;
        bit  legal;
        if (!link_up) begin
            model_clear();
            return;
        end
        c  = int'(dllp_class);
        k  = int'(dllp_kind);
        tc = int'(tlp_class);
        m_err = (dllp_valid && (k == 3 || c == 3)) || (tlp_sent && (m_phase != 2 || tc == 3));
        legal = dllp_valid && k != 3 && c != 3;
        if (m_phase == 0) begin
            if (m_got[0] && m_got[1] && m_got[2]) m_phase = 1;
            else if (legal && k == 0 && !m_got[c]) begin
                m_got[c]       = 1;
                m_lim[2*c]     = int'(dllp_hdr_fc);
                m_lim[2*c + 1] = int'(dllp_data_fc);
                m_inf[2*c]     = (dllp_hdr_fc == 0);
                m_inf[2*c + 1] = (dllp_data_fc == 0);
            end
        end else if (m_phase == 1) begin
            if (legal && (k == 1 || k == 2)) m_phase = 2;
        end else begin
            if (legal && k == 2) begin
                if (!m_inf[2*c])     m_lim[2*c]     = int'(dllp_hdr_fc);
                if (!m_inf[2*c + 1]) m_lim[2*c + 1] = int'(dllp_data_fc);
            end
            if (tlp_sent && tc != 3) begin
                m_cons[2*tc]     = (m_cons[2*tc] + 1) % MOD;
                m_cons[2*tc + 1] = (m_cons[2*tc + 1] + int'(tlp_data_credits)) % MOD;
            end
        end
    endfunction

    function automatic int get_out(int i);
        case (i)
            0: return int'(PH_credit_limit);
            1: return int'(PD_credit_limit);
            2: return int'(NPH_credit_limit);
            3: return int'(NPD_credit_limit);
            4: return int'(CH_credit_limit);
            5: return int'(CD_credit_limit);
            6: return int'(PH_credit_consumed);
            7: return int'(PD_credit_consumed);
            8: return int'(NPH_credit_consumed);
            9: return int'(NPD_credit_consumed);
            10: return int'(CH_credit_consumed);
            default: return int'(CD_credit_consumed);
        endcase
    endfunction

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    function automatic void check_all();
        int infv = 0;
        for (int i = 0; i < 6; i++) if (m_inf[i]) infv |= (1 << i);
        for (int i = 0; i < 6; i++) check({"m_", onames[i]}, get_out(i), m_lim[i]);
        for (int i = 0; i < 6; i++) check({"m_", onames[i+6]}, get_out(i + 6), m_cons[i]);
        check("m_inf", int'(infinite_flags), infv);
        check("m_done", int'(fc_init_done), (m_phase == 2) ? 1 : 0);
        check("m_err", int'(protocol_err), int'(m_err));
    endfunction

    task automatic cyc(input bit lk, input bit dv, input bit [1:0] kd, input bit [1:0] cl,
                       input int hd, input int da, input bit ts, input bit [1:0] tc,
                       input int tdc);
        link_up          = lk;
        dllp_valid       = dv;
        dllp_kind        = kd;
        dllp_class       = cl;
        dllp_hdr_fc      = W'(hd);
        dllp_data_fc     = W'(da);
        tlp_sent         = ts;
        tlp_class        = tc;
        tlp_data_credits = W'(tdc);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
    endtask

    typedef struct {
        string    name;
        bit       dv;
        bit [1:0] kind;
        bit [1:0] cls;
        int       hdr;
        int       data;
        bit       ts;
        bit [1:0] tcls;
        int       tdata;
        bit       exp_done;
        bit       exp_err;
        bit [5:0] exp_inf;
        int       sel;
        int       exp_val;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Handshake and active-phase bring-up; sel picks one counter/limit to pin.
        vecs.push_back('{"init1_p",     1, 2'd0, 2'd0, 20, 100, 0, 2'd0, 0, 0, 0, 6'b000000, 0, 20});
        vecs.push_back('{"init1_np",    1, 2'd0, 2'd1, 10, 0,   0, 2'd0, 0, 0, 0, 6'b001000, 2, 10});
        vecs.push_back('{"init1_cpl",   1, 2'd0, 2'd2, 0,  0,   0, 2'd0, 0, 0, 0, 6'b111000, 1, 100});
        vecs.push_back('{"to_init2",    0, 2'd0, 2'd0, 0,  0,   0, 2'd0, 0, 0, 0, 6'b111000, 5, 0});
        vecs.push_back('{"init2_p",     1, 2'd1, 2'd0, 0,  0,   0, 2'd0, 0, 1, 0, 6'b111000, 0, 20});
        vecs.push_back('{"tlp_p1",      0, 2'd0, 2'd0, 0,  0,   1, 2'd0, 4, 1, 0, 6'b111000, 6, 1});
        vecs.push_back('{"tlp_p2",      0, 2'd0, 2'd0, 0,  0,   1, 2'd0, 4, 1, 0, 6'b111000, 7, 8});
        vecs.push_back('{"tlp_p3",      0, 2'd0, 2'd0, 0,  0,   1, 2'd0, 4, 1, 0, 6'b111000, 7, 12});
        vecs.push_back('{"upd_p",       1, 2'd2, 2'd0, 30, 150, 0, 2'd0, 0, 1, 0, 6'b111000, 0, 30});
        vecs.push_back('{"upd_p_pd",    0, 2'd0, 2'd0, 0,  0,   0, 2'd0, 0, 1, 0, 6'b111000, 1, 150});
        vecs.push_back('{"ph_cons3",    0, 2'd0, 2'd0, 0,  0,   0, 2'd0, 0, 1, 0, 6'b111000, 6, 3});
        vecs.push_back('{"upd_cpl_inf", 1, 2'd2, 2'd2, 5,  5,   0, 2'd0, 0, 1, 0, 6'b111000, 4, 0});
        vecs.push_back('{"cls11",       1, 2'd2, 2'd3, 9,  9,   0, 2'd0, 0, 1, 1, 6'b111000, 0, 30});
        vecs.push_back('{"kind11",      1, 2'd3, 2'd0, 9,  9,   0, 2'd0, 0, 1, 1, 6'b111000, 1, 150});
        vecs.push_back('{"init1_act",   1, 2'd0, 2'd0, 1,  1,   0, 2'd0, 0, 1, 0, 6'b111000, 0, 30});
        vecs.push_back('{"tlp_cpl_inf", 0, 2'd0, 2'd0, 0,  0,   1, 2'd2, 7, 1, 0, 6'b111000, 11, 7});

        rst_n = 1'b0;
        link_up = 1'b0; dllp_valid = 1'b0; tlp_sent = 1'b0;
        dllp_kind = '0; dllp_class = '0; tlp_class = '0;
        dllp_hdr_fc = '0; dllp_data_fc = '0; tlp_data_credits = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_done", int'(fc_init_done), 0);
        check("rst_inf", int'(infinite_flags), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(1, vecs[i].dv, vecs[i].kind, vecs[i].cls, vecs[i].hdr, vecs[i].data,
                vecs[i].ts, vecs[i].tcls, vecs[i].tdata);
            check({vecs[i].name, "_done"}, int'(fc_init_done), int'(vecs[i].exp_done));
            check({vecs[i].name, "_err"}, int'(protocol_err), int'(vecs[i].exp_err));
            check({vecs[i].name, "_inf"}, int'(infinite_flags), int'(vecs[i].exp_inf));
            check({vecs[i].name, "_", onames[vecs[i].sel]}, get_out(vecs[i].sel), vecs[i].exp_val);
        end

        // Same-cycle UpdateFC and TLP on NP; NPD stays infinite from the zero advert.
        cyc(1, 1, 2'd2, 2'd1, 40, 50, 1, 2'd1, 2);
        check("np_same_nph_lim", int'(NPH_credit_limit), 40);
        check("np_same_npd_lim", int'(NPD_credit_limit), 0);
        check("np_same_nph_cons", int'(NPH_credit_consumed), 1);
        check("np_same_npd_cons", int'(NPD_credit_consumed), 2);

        // Posted data counter wrap: 12 + 1008 = 1020, then +8 wraps to 4.
        cyc(1, 0, 2'd0, 2'd0, 0, 0, 1, 2'd0, 1008);
        check("wrap_pd_1020", int'(PD_credit_consumed), 1020);
        cyc(1, 0, 2'd0, 2'd0, 0, 0, 1, 2'd0, 8);
        check("wrap_pd", int'(PD_credit_consumed), 4);
        check("wrap_ph", int'(PH_credit_consumed), 5);
        check("wrap_err", int'(protocol_err), 0);

        // Link drop in active, with strobes high that must be ignored silently.
        cyc(0, 1, 2'd3, 2'd3, 1, 1, 1, 2'd3, 1);
        check("ldown_done", int'(fc_init_done), 0);
        check("ldown_err", int'(protocol_err), 0);
        check("ldown_ph_lim", int'(PH_credit_limit), 0);
        check("ldown_pd_cons", int'(PD_credit_consumed), 0);
        check("ldown_inf", int'(infinite_flags), 0);

        // TLP before init: one-cycle error pulse, counters untouched.
        cyc(1, 0, 2'd0, 2'd0, 0, 0, 1, 2'd0, 5);
        check("init_tlp_err", int'(protocol_err), 1);
        check("init_tlp_ph", int'(PH_credit_consumed), 0);
        idle();
        check("init_tlp_pulse", int'(protocol_err), 0);

        // Repeated InitFC1 for a class is ignored.
        cyc(1, 1, 2'd0, 2'd0, 7, 7, 0, 2'd0, 0);
        cyc(1, 1, 2'd0, 2'd0, 9, 9, 0, 2'd0, 0);
        check("rep_init1_ph", int'(PH_credit_limit), 7);
        cyc(1, 1, 2'd0, 2'd1, 3, 3, 0, 2'd0, 0);
        cyc(1, 1, 2'd0, 2'd2, 4, 4, 0, 2'd0, 0);
        idle();
        check("init2_done", int'(fc_init_done), 0);

        // Asynchronous reset in FC_INIT2, sampled before any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("arst_ph_lim", int'(PH_credit_limit), 0);
        check("arst_ch_lim", int'(CH_credit_limit), 0);
        check_all();
        #2;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit lk, dv, ts;
            bit [1:0] kd, cl, tc;
            int hd, da, tdc;
            lk  = ($urandom_range(0, 99) != 0);
            dv  = 1'($urandom_range(0, 1));
            kd  = 2'($urandom_range(0, 3));
            cl  = 2'($urandom_range(0, 3));
            hd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
            da  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
            ts  = 1'($urandom_range(0, 1));
            tc  = 2'($urandom_range(0, 3));
            tdc = int'($urandom_range(0, MOD - 1));
            cyc(lk, dv, kd, cl, hd, da, ts, tc, tdc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_credit_tracker.md
FC_CREDIT_TRACKER -- requirements
Module: fc_credit_tracker

Interface
REQ-001 The block SHALL have parameter INFO_SIGNALS, default 10, the width of every credit counter and limit.
REQ-002 The block SHALL have parameter HDR_INIT_INF, default 0, the advertised value that means infinite credits.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous assertion, active-low.
REQ-005 Port link_up  input  1  indicates the data link is up; low means the link is down.
REQ-006 Port dllp_valid  input  1  is a one-cycle strobe marking a received FC DLLP.
REQ-007 Port dllp_kind  input  2  is the DLLP kind: 00 InitFC1, 01 InitFC2, 10 UpdateFC, 11 reserved.
REQ-008 Port dllp_class  input  2  is the credit class: 00 Posted, 01 Non-Posted, 10 Completion, 11 reserved.
REQ-009 Port dllp_hdr_fc  input  INFO_SIGNALS  is the advertised header credit value.
REQ-010 Port dllp_data_fc  input  INFO_SIGNALS  is the advertised data credit value.
REQ-011 Port tlp_sent  input  1  is a one-cycle strobe marking a TLP committed to the transmitter.
REQ-012 Port tlp_class  input  2  is the class of the sent TLP, encoded as in dllp_class.
REQ-013 Port tlp_data_credits  input  INFO_SIGNALS  is the data credits the sent TLP consumes (0 for header-only TLPs).
REQ-014 Ports PH/PD/NPH/NPD/CH/CD_credit_limit  output  INFO_SIGNALS each  are the registered credit limits, feeding the gating stage.
REQ-015 Ports PH/PD/NPH/NPD/CH/CD_credit_consumed  output  INFO_SIGNALS each  are the registered credits-consumed counters, feeding the gating stage.
REQ-016 Port infinite_flags  output  6  holds per-type infinite flags, bit order [5:0] = CD,CH,NPD,NPH,PD,PH.
REQ-017 Port fc_init_done  output  1  is high only in state FC_ACTIVE.
REQ-018 Port protocol_err  output  1  is a one-cycle pulse flagging an illegal event.

Function
REQ-019 The state machine SHALL have three states: FC_INIT1, FC_INIT2 and FC_ACTIVE.
REQ-020 In FC_INIT1, an InitFC1 for class c SHALL load c's header and data limits from dllp_hdr_fc/dllp_data_fc, set got[c], and set the infinite flag of each type whose advertised value equals 0.
REQ-021 A repeated InitFC1 for a class already in got SHALL be ignored, with no limit change.
REQ-022 Once got equals 3'b111, the state SHALL move FC_INIT1 -> FC_INIT2 on the next clock edge.
REQ-023 In FC_INIT2, any InitFC2 or UpdateFC, of any class, SHALL move the state to FC_ACTIVE on the next clock edge.
REQ-024 InitFC1 received in FC_INIT2 SHALL be ignored.
REQ-025 In FC_ACTIVE, an UpdateFC SHALL overwrite the limit of each non-infinite type of its class.
REQ-026 In FC_ACTIVE, an UpdateFC SHALL leave the limit of each infinite type unchanged.
REQ-027 InitFC1 and InitFC2 received in FC_ACTIVE SHALL be ignored.
REQ-028 In FC_ACTIVE, tlp_sent SHALL add 1 to the class header-consumed counter and tlp_data_credits to the class data-consumed counter, modulo 2**INFO_SIGNALS, wrapping silently.
REQ-029 Consumed counters of infinite types SHALL still count.
REQ-030 An UpdateFC and a tlp_sent on the same class in the same cycle SHALL both take effect in that cycle.
REQ-031 tlp_sent outside FC_ACTIVE SHALL change no counter and SHALL pulse protocol_err.
REQ-032 Class 11 or kind 11, with its strobe high, SHALL be ignored and SHALL pulse protocol_err.
REQ-033 All outputs SHALL be registered, updating on the clock edge that samples the input event (1-cycle latency); there is no combinational path from inputs to outputs.
REQ-034 link_up low SHALL, synchronously on the next clock edge and overriding all other inputs, return the state to FC_INIT1 and clear all limits, consumed counters, got bits and infinite flags.
REQ-035 A link_up drop in any state, including FC_ACTIVE, SHALL behave as REQ-034.
REQ-036 While link_up is low, dllp_valid and tlp_sent SHALL be ignored without error.

Reset
REQ-037 rst_n low SHALL asynchronously force state FC_INIT1, got = 0, every limit and consumed output = 0, infinite_flags = 0, fc_init_done = 0 and protocol_err = 0.
REQ-038 Release of rst_n SHALL take effect on the first clock edge at which rst_n is high; reset mid-operation discards all credit state.

Verification
REQ-039 Scenario: InitFC1 P(hdr 20, data 100), NP(10, 0), Cpl(0, 0), then InitFC2 P -> PH_limit=20, PD_limit=100, NPH_limit=10, infinite_flags=6'b111000, fc_init_done high two cycles after the Cpl InitFC1.
REQ-040 Scenario: in FC_ACTIVE, send P TLPs with 4 data credits each, 3 times -> PH_consumed=3, PD_consumed=12; then UpdateFC P(hdr 30, data 150) -> PH_limit=30, PD_limit=150.
REQ-041 Scenario: PD_consumed=1020 (INFO_SIGNALS=10), tlp_sent P with 8 data credits -> PD_consumed=4, PH_consumed incremented by 1, no error.
REQ-042 Scenario: UpdateFC NP and tlp_sent NP with 2 data credits in the same cycle -> new NP limits and NPH_consumed+1, NPD_consumed+2, both visible next cycle.
REQ-043 Scenario: tlp_sent while in FC_INIT1 -> protocol_err pulses for 1 cycle, counters stay 0; a class-11 DLLP in FC_ACTIVE -> protocol_err pulse, no change.
REQ-044 Scenario: link_up dropped in FC_ACTIVE with nonzero counters -> next cycle state FC_INIT1, all outputs 0; rst_n asserted mid-FC_INIT2 -> outputs 0 immediately, without waiting for a clock edge.
